// File: rtl/dircc_node_rx_packet_writer.sv
// dircc_node_rx_packet_writer: writes received flit packets into a slot ring in processing memory and hands them to the Nios via CSR/irq.
module dircc_node_rx_packet_writer #(
  parameter logic [13:0] BASE_ADDR  = 14'd8192,
  parameter int          RING_SLOTS = 16,
  parameter int          SLOT_WORDS = 32
) (
  input  logic        clk_i,
  input  logic        reset_i,
  input  logic [15:0] rx_data_i,
  input  logic        rx_valid_i,
  input  logic        rx_sop_i,
  input  logic        rx_eop_i,
  output logic        rx_ready_o,
  output logic [13:0] mem_address_o,
  output logic [15:0] mem_writedata_o,
  output logic [1:0]  mem_byteenable_o,
  output logic        mem_chipselect_o,
  output logic        mem_write_o,
  input  logic [1:0]  csr_address_i,
  input  logic        csr_read_i,
  input  logic        csr_write_i,
  input  logic [31:0] csr_writedata_i,
  output logic [31:0] csr_readdata_o,
  output logic        irq_o
);
  localparam int HW = $clog2(RING_SLOTS);
  localparam int IW = $clog2(SLOT_WORDS);
  localparam logic [IW-1:0] IDX_MAX = IW'(SLOT_WORDS - 1);
  localparam logic [5:0] FULL = 6'(RING_SLOTS);

  typedef enum logic [2:0] {IDLE, DATA, LEN, PUB, DROP} state_t;

  state_t state_q, state_d;
  logic [HW-1:0] head_q, head_d, tail_q, tail_d;
  logic [5:0] count_q, count_d;
  logic [IW-1:0] idx_q, idx_d, off;
  logic ovf_q, ovf_d, trunc_q, trunc_d, en_q, en_d, irqen_q, irqen_d;
  logic wr_q, wr_d, irq_q, irq_d;
  logic [13:0] addr_q, addr_d;
  logic [15:0] wdata_q, wdata_d;
  logic [31:0] rdata_q, rdata_d;
  logic acc, pop, pub;
  logic unused_bits;

  assign unused_bits = ^{csr_writedata_i[31:9], csr_writedata_i[7:2]};

  always_comb begin
    state_d = state_q;
    head_d = head_q;
    tail_d = tail_q;
    idx_d = idx_q;
    ovf_d = ovf_q;
    trunc_d = trunc_q;
    en_d = en_q;
    irqen_d = irqen_q;
    wr_d = 1'b0;
    off = '0;
    wdata_d = '0;
    pub = 1'b0;
    rx_ready_o = state_q == IDLE ? en_q : (state_q == DATA || state_q == DROP);
    acc = rx_valid_i & rx_ready_o;
    pop = csr_write_i && csr_address_i == 2'd2 && count_q != 6'd0;
    if (csr_write_i && csr_address_i == 2'd3) begin
      en_d = csr_writedata_i[0];
      irqen_d = csr_writedata_i[1];
      if (csr_writedata_i[8]) begin
        ovf_d = 1'b0;
        trunc_d = 1'b0;
      end
    end
    case (state_q)
      IDLE: if (acc && rx_sop_i) begin
        if (count_q == FULL) begin
          ovf_d = 1'b1;
          state_d = rx_eop_i ? IDLE : DROP;
        end else begin
          wr_d = 1'b1;
          off = IW'(1);
          wdata_d = rx_data_i;
          idx_d = IW'(1);
          state_d = rx_eop_i ? LEN : DATA;
        end
      end
      DATA: if (acc) begin
        if (idx_q == IDX_MAX) trunc_d = 1'b1;
        else begin
          wr_d = 1'b1;
          off = idx_q + 1'b1;
          wdata_d = rx_data_i;
          idx_d = idx_q + 1'b1;
        end
        if (rx_eop_i) state_d = LEN;
      end
      // idx never passes IDX_MAX, so it is already the saturated length
      LEN: begin
        wr_d = 1'b1;
        wdata_d = 16'(idx_q);
        state_d = PUB;
      end
      PUB: begin
        pub = 1'b1;
        head_d = head_q + 1'b1;
        state_d = IDLE;
      end
      DROP: if (acc && rx_eop_i) state_d = IDLE;
      default: state_d = IDLE;
    endcase
    if (pop) tail_d = tail_q + 1'b1;
    count_d = count_q + {5'd0, pub} - {5'd0, pop};
    addr_d = wr_d ? BASE_ADDR + 14'(head_q) * 14'(SLOT_WORDS) + 14'(off) : 14'd0;
    irq_d = irqen_d & (count_d != 6'd0);
    rdata_d = !csr_read_i ? rdata_q :
              csr_address_i == 2'd0 ? {22'd0, trunc_q, ovf_q, 2'b00, count_q} :
              csr_address_i == 2'd1 ? {11'd0, 5'(tail_q), 11'd0, 5'(head_q)} :
              csr_address_i == 2'd3 ? {30'd0, irqen_q, en_q} : 32'd0;
  end

  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      state_q <= IDLE;
      head_q <= '0;
      tail_q <= '0;
      count_q <= '0;
      idx_q <= '0;
      ovf_q <= 1'b0;
      trunc_q <= 1'b0;
      en_q <= 1'b0;
      irqen_q <= 1'b0;
      wr_q <= 1'b0;
      addr_q <= '0;
      wdata_q <= '0;
      rdata_q <= '0;
      irq_q <= 1'b0;
    end else begin
      state_q <= state_d;
      head_q <= head_d;
      tail_q <= tail_d;
      count_q <= count_d;
      idx_q <= idx_d;
      ovf_q <= ovf_d;
      trunc_q <= trunc_d;
      en_q <= en_d;
      irqen_q <= irqen_d;
      wr_q <= wr_d;
      addr_q <= addr_d;
      wdata_q <= wdata_d;
      rdata_q <= rdata_d;
      irq_q <= irq_d;
    end
  end

  assign mem_address_o = addr_q;
  assign mem_writedata_o = wdata_q;
  assign mem_byteenable_o = {2{wr_q}};
  assign mem_chipselect_o = wr_q;
  assign mem_write_o = wr_q;
  assign csr_readdata_o = rdata_q;
  assign irq_o = irq_q;
endmodule

// File: tb/tb_dircc_node_rx_packet_writer.sv
// tb_dircc_node_rx_packet_writer: directed bench for the rx packet writer with hand-computed expectations.
module tb_dircc_node_rx_packet_writer;
  logic clk = 1'b0, reset = 1'b1;
  logic [15:0] rx_data = '0;
  logic rx_valid = 1'b0, rx_sop = 1'b0, rx_eop = 1'b0, rx_ready;
  logic [13:0] mem_address;
  logic [15:0] mem_writedata;
  logic [1:0] mem_byteenable, csr_address = '0;
  logic mem_chipselect, mem_write, csr_read = 1'b0, csr_write = 1'b0, irq;
  logic [31:0] csr_writedata = '0, csr_readdata, d;
  int tests = 0, fails = 0, be_bad = 0, cyc;
  logic [29:0] wq[$];

  dircc_node_rx_packet_writer dut (
    .clk_i(clk), .reset_i(reset),
    .rx_data_i(rx_data), .rx_valid_i(rx_valid), .rx_sop_i(rx_sop), .rx_eop_i(rx_eop), .rx_ready_o(rx_ready),
    .mem_address_o(mem_address), .mem_writedata_o(mem_writedata), .mem_byteenable_o(mem_byteenable),
    .mem_chipselect_o(mem_chipselect), .mem_write_o(mem_write),
    .csr_address_i(csr_address), .csr_read_i(csr_read), .csr_write_i(csr_write),
    .csr_writedata_i(csr_writedata), .csr_readdata_o(csr_readdata), .irq_o(irq)
  );

  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (mem_write) wq.push_back({mem_address, mem_writedata});
    if (mem_write ? (mem_byteenable !== 2'b11 || mem_chipselect !== 1'b1)
                  : (mem_byteenable !== 2'b00 || mem_chipselect !== 1'b0)) be_bad++;
  end

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic check_wr(input string tag, input logic [13:0] a, input logic [15:0] v);
    logic [29:0] o;
    o = (wq.size() != 0) ? wq.pop_front() : 'x;
    check(tag, {2'b00, o}, {2'b00, a, v});
  endtask

  task automatic rd(input logic [1:0] a, output logic [31:0] v);
    csr_address = a;
    csr_read = 1'b1;
    tick();
    csr_read = 1'b0;
    v = csr_readdata;
  endtask

  task automatic wr(input logic [1:0] a, input logic [31:0] v);
    csr_address = a;
    csr_writedata = v;
    csr_write = 1'b1;
    tick();
    csr_write = 1'b0;
  endtask

  // returns in the cycle after the last flit was accepted
  task automatic send(input int n, input logic [15:0] d0, input bit last_eop, output int c);
    bit acc;
    c = 0;
    for (int i = 0; i < n; i++) begin
      rx_valid = 1'b1;
      rx_sop = (i == 0);
      rx_eop = last_eop && (i == n - 1);
      rx_data = d0 + 16'(i);
      acc = 1'b0;
      while (!acc && c < 400) begin
        acc = rx_ready;
        tick();
        c++;
      end
    end
    rx_valid = 1'b0;
    rx_sop = 1'b0;
    rx_eop = 1'b0;
    check("handshake_timeout", 32'(c >= 400), 32'd0);
  endtask

  initial begin
    tick();
    check("rst_ready", 32'(rx_ready), 32'd0);
    check("rst_memwr", 32'(mem_write), 32'd0);
    check("rst_irq", 32'(irq), 32'd0);
    check("rst_rdata", csr_readdata, 32'd0);
    reset = 1'b0;
    tick();
    wr(2'd3, 32'd3);
    send(3, 16'hA001, 1'b1, cyc);
    check("p1_ready_n1", 32'(rx_ready), 32'd0);
    tick();
    check("p1_ready_n2", 32'(rx_ready), 32'd0);
    check("p1_irq_n2", 32'(irq), 32'd0);
    tick();
    check("p1_ready_n3", 32'(rx_ready), 32'd1);
    check("p1_irq_n3", 32'(irq), 32'd1);
    check_wr("p1_w1", 14'd8193, 16'hA001);
    check_wr("p1_w2", 14'd8194, 16'hA002);
    check_wr("p1_w3", 14'd8195, 16'hA003);
    check_wr("p1_hdr", 14'd8192, 16'h0003);
    check("p1_qempty", 32'(wq.size()), 32'd0);
    rd(2'd0, d);
    check("p1_status", d, 32'h1);
    // single-flit packet into slot 1, with a POP landing in its PUB cycle
    send(1, 16'h5555, 1'b1, cyc);
    check("p2_ready_n1", 32'(rx_ready), 32'd0);
    tick();
    check("p2_ready_n2", 32'(rx_ready), 32'd0);
    csr_address = 2'd2;
    csr_write = 1'b1;
    tick();
    csr_write = 1'b0;
    check("p2_ready_n3", 32'(rx_ready), 32'd1);
    check_wr("p2_w1", 14'd8225, 16'h5555);
    check_wr("p2_hdr", 14'd8224, 16'h0001);
    rd(2'd0, d);
    check("p2_status", d, 32'h1);
    rd(2'd1, d);
    check("p2_headtail", d, 32'h0001_0002);
    // 40 flits into slot 2: 31 payload writes, then truncation
    send(40, 16'hB000, 1'b1, cyc);
    check("p3_cycles", 32'(cyc), 32'd40);
    tick();
    tick();
    for (int i = 0; i < 31; i++) check_wr("p3_w", 14'(8257 + i), 16'hB000 + 16'(i));
    check_wr("p3_hdr", 14'd8256, 16'h001F);
    check("p3_qempty", 32'(wq.size()), 32'd0);
    rd(2'd0, d);
    check("p3_status", d, 32'h0000_0202);
    for (int k = 0; k < 14; k++) send(1, 16'h7000 + 16'(k), 1'b1, cyc);
    tick();
    tick();
    wq.delete();
    rd(2'd0, d);
    check("fill_status", d, 32'h0000_0210);
    send(3, 16'hE000, 1'b1, cyc);
    tick();
    tick();
    check("ovf_nowrites", 32'(wq.size()), 32'd0);
    rd(2'd0, d);
    check("ovf_status", d, 32'h0000_0310);
    wr(2'd2, 32'd0);
    rd(2'd0, d);
    check("pop_status", d, 32'h0000_030F);
    rd(2'd1, d);
    check("pop_headtail", d, 32'h0002_0001);
    wr(2'd3, 32'h0000_0103);
    rd(2'd0, d);
    check("clr_status", d, 32'h0000_000F);
    rd(2'd3, d);
    check("ctrl_rd", d, 32'h3);
    check("irq_pending", 32'(irq), 32'd1);
    // asynchronous reset in the middle of a packet
    send(5, 16'hD000, 1'b0, cyc);
    #1 reset = 1'b1;
    #1;
    check("arst_memwr", 32'(mem_write), 32'd0);
    check("arst_ready", 32'(rx_ready), 32'd0);
    check("arst_irq", 32'(irq), 32'd0);
    check("arst_rdata", csr_readdata, 32'd0);
    tick();
    reset = 1'b0;
    tick();
    wq.delete();
    rd(2'd0, d);
    check("arst_status", d, 32'd0);
    rd(2'd3, d);
    check("arst_ctrl", d, 32'd0);
    wr(2'd3, 32'd1);
    send(2, 16'hC001, 1'b1, cyc);
    tick();
    tick();
    check_wr("p5_w1", 14'd8193, 16'hC001);
    check_wr("p5_w2", 14'd8194, 16'hC002);
    check_wr("p5_hdr", 14'd8192, 16'h0002);
    rd(2'd0, d);
    check("p5_status", d, 32'h1);
    rd(2'd1, d);
    check("p5_headtail", d, 32'h0000_0001);
    check("p5_irq_disabled", 32'(irq), 32'd0);
    check("be_cs", 32'(be_bad), 32'd0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
